axi_burst_reader: RTL and testbench

- Parametrised AXI4 read master. Streams a software-programmed region of memory into a downstream FIFO.
- The region is set by a base address and a length in beats. The block splits it into INCR bursts that never exceed MAX_BURST and never cross a 4 KB boundary.
- Several read bursts may be outstanding at once.
- FIFO flow control is credit-based: an AR is issued only when the FIFO has already reserved room for the whole burst.
- Sits between the memory interconnect and the pixel/sample FIFOs. Replaces the single-burst fixed-address reader.

---
 rtl/axi_burst_reader.sv | 196 +++++++++++++++++++
 tb/tb_axi_burst_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_reader.sv
// AXI4 read master that streams a programmed region into a credit-managed FIFO.
// Define AXI_BURST_READER_ERR_EN to add the err/err_addr error-capture outputs.
module axi_burst_reader #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int AXI_ID          = 0,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 24,
  parameter int FREE_WIDTH      = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_cfg_addr,
  input  logic [LEN_WIDTH-1:0]  i_cfg_beats,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic [7:0]            o_m_axi_arlen,
  output logic [2:0]            o_m_axi_arsize,
  output logic [1:0]            o_m_axi_arburst,
  output logic [ID_WIDTH-1:0]   o_m_axi_arid,
  output logic [2:0]            o_m_axi_arprot,
  output logic                  o_m_axi_arvalid,
  input  logic                  i_m_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic [1:0]            i_m_axi_rresp,
  input  logic                  i_m_axi_rlast,
  input  logic                  i_m_axi_rvalid,
  output logic                  o_m_axi_rready,
  input  logic [FREE_WIDTH-1:0] i_fifo_free,
  output logic                  o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] o_fifo_wr_data
`ifdef AXI_BURST_READER_ERR_EN
  ,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_err_addr
`endif
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BPB);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int RES_W = ((FREE_WIDTH > 9) ? FREE_WIDTH : 9) + 1;
  localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [OUT_W-1:0]      MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [RES_W-1:0]      r_reserved;
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;

  logic [12:0]   w_room;
  logic [CW-1:0] w_room_cw, w_rem_cw, w_cap_cw, w_len_cw;
  logic [8:0]    w_len;
  logic [8:0]    w_hs_len;
  logic          w_ar_hs, w_wr, w_issue, w_busy, w_done;

  // Beats left before the next 4 KB page boundary; address is always beat aligned.
  assign w_room    = (13'd4096 - {1'b0, r_addr[11:0]}) >> SIZE;
  assign w_room_cw = CW'(w_room);
  assign w_rem_cw  = CW'(r_remaining);
  assign w_cap_cw  = (w_room_cw < CW'(MAX_BURST)) ? w_room_cw : CW'(MAX_BURST);
  assign w_len_cw  = (w_rem_cw < w_cap_cw) ? w_rem_cw : w_cap_cw;
  assign w_len     = w_len_cw[8:0];
  assign w_hs_len  = {1'b0, r_arlen} + 9'd1;

  assign w_ar_hs = r_arvalid & i_m_axi_arready;
  assign w_wr    = i_m_axi_rvalid & w_busy;
  assign w_issue = (r_state == S_ISSUE) & ~r_arvalid & (r_outstanding < MAX_OUT_C)
                 & (RES_W'(i_fifo_free) >= r_reserved + RES_W'(w_len));

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) w_state_next = (i_cfg_beats == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: if (w_ar_hs && (r_remaining == LEN_WIDTH'(w_hs_len))) w_state_next = S_DRAIN;
      S_DRAIN: if (r_outstanding == '0) w_state_next = S_DONE;
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_reserved    <= '0;
      r_outstanding <= '0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_arlen       <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_addr      <= i_cfg_addr & ADDR_MASK;
        r_remaining <= i_cfg_beats;
      end
      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr  <= r_addr;
        r_arlen   <= 8'(w_len - 9'd1);
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_addr      <= r_addr + (ADDR_WIDTH'(w_hs_len) << SIZE);
        r_remaining <= r_remaining - LEN_WIDTH'(w_hs_len);
      end
      // Net update: an AR handshake and an R beat may land in the same cycle.
      r_reserved    <= r_reserved + (w_ar_hs ? RES_W'(w_hs_len) : '0)
                                  - (w_wr ? RES_W'(1) : '0);
      r_outstanding <= r_outstanding + OUT_W'(w_ar_hs) - OUT_W'(w_wr & i_m_axi_rlast);
    end
  end

  assign o_busy          = w_busy;
  assign o_done          = w_done;
  assign o_m_axi_araddr  = r_araddr;
  assign o_m_axi_arlen   = r_arlen;
  assign o_m_axi_arsize  = 3'(SIZE);
  assign o_m_axi_arburst = 2'b01;
  assign o_m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign o_m_axi_arprot  = 3'b000;
  assign o_m_axi_arvalid = r_arvalid;
  assign o_m_axi_rready  = w_busy;
  assign o_fifo_wr_en    = w_wr;
  assign o_fifo_wr_data  = i_m_axi_rdata;

`ifdef AXI_BURST_READER_ERR_EN
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ADDR_WIDTH-1:0] r_afifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Burst addresses in issue order; the head belongs to the burst now returning data.
  always_ff @(posedge clk) begin
    if (w_ar_hs) r_afifo[r_wr_ptr] <= r_araddr;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (w_ar_hs)               r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_wr && i_m_axi_rlast) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (r_state == S_IDLE && i_start) begin
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end else if (w_wr && i_m_axi_rresp[1] && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= r_afifo[r_rd_ptr];
      end
    end
  end

  assign o_err      = r_err;
  assign o_err_addr = r_err_addr;

  wire w_unused = &{1'b0, i_m_axi_rresp[0], w_len_cw[CW-1:9]};
`else
  wire w_unused = &{1'b0, i_m_axi_rresp, w_len_cw[CW-1:9]};
`endif

endmodule

// File: tb/tb_axi_burst_reader.sv
// Randomized scoreboard bench for axi_burst_reader: AXI slave model, FIFO credit model
// and an arithmetic reference of the expected burst split and data stream.
`timescale 1ns/1ps
module tb_axi_burst_reader;
  localparam int AW = 32, DW = 64, IW = 4, MB = 16, MO = 4, LW = 24, FW = 10;
  localparam int BPB = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] cfg_addr;
  logic [LW-1:0] cfg_beats;
  logic          busy, done;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, rresp;
  logic [IW-1:0] arid;
  logic          arvalid, arready, rlast, rvalid, rready, fifo_wr_en;
  logic [DW-1:0] rdata, fifo_wr_data;
  logic [FW-1:0] fifo_free;
`ifdef AXI_BURST_READER_ERR_EN
  logic          err;
  logic [AW-1:0] err_addr;
`endif

  axi_burst_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0), .MAX_BURST(MB),
    .MAX_OUTSTANDING(MO), .LEN_WIDTH(LW), .FREE_WIDTH(FW)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(start), .i_cfg_addr(cfg_addr), .i_cfg_beats(cfg_beats),
    .o_busy(busy), .o_done(done), .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen),
    .o_m_axi_arsize(arsize), .o_m_axi_arburst(arburst), .o_m_axi_arid(arid),
    .o_m_axi_arprot(arprot), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
    .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast),
    .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready), .i_fifo_free(fifo_free),
    .o_fifo_wr_en(fifo_wr_en), .o_fifo_wr_data(fifo_wr_data)
`ifdef AXI_BURST_READER_ERR_EN
    , .o_err(err), .o_err_addr(err_addr)
`endif
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] addr; int len; int rdy_cyc; } burst_t;

  ar_t           exp_ar[$];
  logic [63:0]   exp_data[$];
  burst_t        slv_q[$];
  int            exp_done = 0;
  int            done_cnt = 0;
  int            total = 0, bad = 0;
  int            cyc = 0;
  int            cap = 512, occ = 0, ar_pct = 100;
  logic [31:0]   salt = 32'h1234_5678;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {a ^ salt, ~a};
  endfunction

  // Reference: split the region into INCR bursts capped by MAX_BURST and the 4 KB page.
  task automatic model_xfer(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    int rem, room, len;
    a   = addr & ~32'(BPB - 1);
    rem = beats;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / BPB;
      len  = rem;
      if (len > MB)   len = MB;
      if (len > room) len = room;
      exp_ar.push_back('{a, 8'(len - 1)});
      for (int i = 0; i < len; i++) exp_data.push_back(beat_data(a + 32'(i * BPB)));
      a   = a + 32'(len * BPB);
      rem = rem - len;
    end
    exp_done++;
  endtask

  // AR channel slave: random ready, accepted bursts queued with a return delay.
  initial begin : ar_slave
    burst_t b;
    arready = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rstn) begin arready = 1'b0; continue; end
      arready = (int'($urandom_range(1, 100)) <= ar_pct);
      #2;
      if (arvalid && arready) begin
        b.addr    = araddr;
        b.len     = int'(arlen);
        b.rdy_cyc = cyc + (($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 50))
                                                       : int'($urandom_range(0, 4)));
        slv_q.push_back(b);
      end
    end
  end

  // R channel slave: in-order beats with random gaps; rvalid held until accepted.
  initial begin : r_slave
    burst_t cur;
    bit active, r_hs;
    int beat;
    active = 0; r_hs = 0; beat = 0;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk); #1;
      if (!rstn) begin
        rvalid = 1'b0; rlast = 1'b0; active = 0; r_hs = 0; slv_q.delete();
        continue;
      end
      if (!(rvalid && !r_hs)) begin
        if (r_hs) begin
          if (rlast) active = 0;
          else       beat++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        if (!active && slv_q.size() > 0 && slv_q[0].rdy_cyc <= cyc) begin
          cur = slv_q.pop_front(); active = 1; beat = 0;
        end
        if (active && $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1;
          rdata  = beat_data(cur.addr + 32'(beat * BPB));
          rlast  = (beat == cur.len);
        end
      end
      #2;
      r_hs = rvalid && rready;
    end
  end

  // Downstream FIFO: occupancy grows on writes, drains randomly; never may exceed cap.
  initial begin : fifo_model
    bit wr_l;
    wr_l = 0;
    fifo_free = FW'(cap);
    forever begin
      @(negedge clk); #1;
      if (!rstn) begin
        occ = 0; wr_l = 0;
      end else begin
        if (wr_l) begin
          occ++;
          chk("fifo_no_overflow", 64'(occ <= cap), 64'(1));
        end
        if (occ > 0 && $urandom_range(1, 100) <= 60) occ--;
      end
      fifo_free = FW'(cap - occ);
      #2;
      wr_l = fifo_wr_en && rstn;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an AR, a FIFO write or done.
  initial begin : monitor
    logic p_arv, p_arr, p_done;
    logic [31:0] p_addr;
    logic [7:0] p_len;
    int outst;
    ar_t e;
    logic [63:0] d;
    p_arv = 0; p_arr = 0; p_done = 0; p_addr = '0; p_len = '0; outst = 0;
    forever begin
      @(negedge clk); #3;
      if (!rstn) begin p_arv = 0; p_done = 0; outst = 0; continue; end
      chk("rready_eq_busy", 64'(rready), 64'(busy));
      chk("wr_en", 64'(fifo_wr_en), 64'(rvalid & rready));
      if (p_arv && !p_arr) begin
        chk("ar_hold_valid", 64'(arvalid), 64'(1));
        chk("ar_hold_addr", 64'(araddr), 64'(p_addr));
        chk("ar_hold_len", 64'(arlen), 64'(p_len));
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) chk("unexpected_ar", 64'(arvalid), 64'(0));
        else begin
          e = exp_ar.pop_front();
          chk("ar_addr", 64'(araddr), 64'(e.addr));
          chk("ar_len", 64'(arlen), 64'(e.len));
        end
        chk("ar_no_4k_cross", 64'((int'(araddr[11:0]) + (int'(arlen) + 1) * BPB) <= 4096), 64'(1));
        chk("ar_size", 64'(arsize), 64'(3));
        chk("ar_burst", 64'(arburst), 64'(1));
        chk("ar_id_prot", 64'({arid, arprot}), 64'(0));
        outst++;
        chk("outstanding_limit", 64'(outst <= MO), 64'(1));
      end
      if (fifo_wr_en) begin
        if (exp_data.size() == 0) chk("unexpected_wr", 64'(fifo_wr_en), 64'(0));
        else begin
          d = exp_data.pop_front();
          chk("wr_data", fifo_wr_data, d);
        end
      end
      if (rvalid && rready && rlast) outst--;
      if (p_done) chk("busy_after_done", 64'(busy), 64'(0));
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'(1));
        if (exp_done == 0) chk("unexpected_done", 64'(done), 64'(0));
        else begin
          exp_done--;
          done_cnt++;
          chk("done_scoreboard_empty", 64'(exp_ar.size() + exp_data.size()), 64'(0));
          chk("done_outstanding", 64'(outst), 64'(0));
`ifdef AXI_BURST_READER_ERR_EN
          chk("err_clear", 64'(err), 64'(0));
`endif
        end
      end
      p_arv = arvalid; p_arr = arready; p_addr = araddr; p_len = arlen; p_done = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_arvalid"}, 64'(arvalid), 64'(0));
    chk({tag, "_araddr"}, 64'(araddr), 64'(0));
    chk({tag, "_arlen"}, 64'(arlen), 64'(0));
    chk({tag, "_rready"}, 64'(rready), 64'(0));
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'(0));
  endtask

  task automatic run_xfer(input logic [31:0] addr, input int beats, input int capv,
                          input int arpct, input bit poke);
    int d0, nar;
    for (int i = 0; i < 3000 && occ != 0; i++) @(negedge clk);
    cap = capv; ar_pct = arpct; salt = $urandom;
    nar = exp_ar.size();
    model_xfer(addr, beats);
    nar = exp_ar.size() - nar;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; cfg_addr = addr; cfg_beats = LW'(beats);
    @(negedge clk);
    start = 1'b0; cfg_addr = $urandom; cfg_beats = LW'($urandom);
    if (beats == 0) begin
      #3;
      chk("zero_beats_done", 64'(done), 64'(1));
    end
    if (poke) begin
      repeat (6) @(negedge clk);
      if (busy) begin
        start = 1'b1; cfg_addr = 32'h0000_4000; cfg_beats = LW'(5);
        @(negedge clk);
        start = 1'b0;
      end
    end
    for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
    chk("xfer_completed", 64'(done_cnt - d0), 64'(1));
    repeat (2) @(negedge clk);
    $display("xfer addr=0x%08h beats=%0d cap=%0d arready%%=%0d bursts=%0d", addr, beats,
             capv, arpct, nar);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    start = 1'b0; cfg_addr = '0; cfg_beats = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_reset_outputs("reset");
    chk("reset_arsize", 64'(arsize), 64'(3));
    chk("reset_arburst", 64'(arburst), 64'(1));
    @(negedge clk);
    rstn = 1'b1;

    run_xfer(32'h0000_1000, 40, 512, 100, 1'b1);
    run_xfer(32'h0000_0FC0, 16, 512, 100, 1'b0);
    run_xfer(32'h0000_2000, 32, 20, 100, 1'b0);
    run_xfer(32'h0000_3000, 0, 512, 100, 1'b0);
    run_xfer(32'h0000_5F90, 64, 512, 30, 1'b0);
    for (int n = 0; n < 10; n++)
      run_xfer($urandom & 32'h000F_FFFF, int'($urandom_range(1, 120)),
               int'($urandom_range(16, 600)), int'($urandom_range(20, 100)), 1'b0);

    // Abort in the middle of a long transfer.
    cap = 512; ar_pct = 100;
    model_xfer(32'h0000_8000, 200);
    @(negedge clk);
    start = 1'b1; cfg_addr = 32'h0000_8000; cfg_beats = LW'(200);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    exp_ar.delete(); exp_data.delete(); exp_done = 0;
    @(negedge clk); #3;
    check_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    $display("xfer addr=0x00008000 beats=200 aborted by reset");

    run_xfer(32'h0000_9008, 50, 64, 80, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
